// File: rtl/key_gen.sv
// Push-button emulator: plays a bounced single click, double click or long press
// onto an active-low key line, with busy/done handshaking and an error pulse for bad codes.
module key_gen #(
  parameter int BOUNCE_CYC = 4,
  parameter int BOUNCE_N   = 2,
  parameter int SHORT_CYC  = 20,
  parameter int LONG_CYC   = 100,
  parameter int GAP_CYC    = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  output logic       cmd_ready,
  output logic       key_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] CMD_SINGLE = 3'b001;
  localparam logic [2:0] CMD_DOUBLE = 3'b010;
  localparam logic [2:0] CMD_LONG   = 3'b100;

  localparam int MAX_AB  = (BOUNCE_CYC > SHORT_CYC) ? BOUNCE_CYC : SHORT_CYC;
  localparam int MAX_CD  = (LONG_CYC > GAP_CYC) ? LONG_CYC : GAP_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int GW      = (BOUNCE_N > 1) ? $clog2(BOUNCE_N) : 1;

  // Counters hold "cycles remaining minus one" so a phase ends when they read zero.
  localparam logic [CNT_W-1:0] BC_LAST    = CNT_W'(BOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [GW-1:0]    G_LAST     = GW'((BOUNCE_N > 0) ? BOUNCE_N - 1 : 0);
  localparam logic [GW-1:0]    G_ONE      = GW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_P_BNC, S_HOLD, S_R_BNC, S_GAP, S_BADCMD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]    gl_q, gl_d;
  logic             press_q, press_d;
  logic [2:0]       cmd_q, cmd_d;
  logic             key_q, key_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             press_end;
  logic             code_ok;
  logic [2:0]       press_cmd;
  logic [CNT_W-1:0] hold_last;

  assign code_ok   = (cmd == CMD_SINGLE) || (cmd == CMD_DOUBLE) || (cmd == CMD_LONG);
  // With no bounce the hold length is needed in the accepting cycle, before cmd_q is valid.
  assign press_cmd = (state_q == S_IDLE) ? cmd : cmd_q;
  assign hold_last = (press_cmd == CMD_LONG) ? LONG_LAST : SHORT_LAST;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gl_q    <= '0;
      press_q <= 1'b0;
      cmd_q   <= '0;
      key_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gl_q    <= gl_d;
      press_q <= press_d;
      cmd_q   <= cmd_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gl_d      = gl_q;
    press_d   = press_q;
    cmd_d     = cmd_q;
    key_d     = key_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    press_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        key_d  = 1'b1;
        busy_d = 1'b0;
        if (cmd_valid && !busy_q) begin
          cmd_d   = cmd;
          press_d = 1'b0;
          gl_d    = '0;
          busy_d  = 1'b1;
          if (code_ok) begin
            key_d = 1'b0;
            if (BOUNCE_N == 0) begin
              state_d = S_HOLD;
              cnt_d   = hold_last;
            end else begin
              state_d = S_P_BNC;
              cnt_d   = BC_LAST;
            end
          end else begin
            state_d = S_BADCMD;
            cnt_d   = '0;
          end
        end
      end
      S_P_BNC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!key_q) begin
          key_d = 1'b1;
          cnt_d = BC_LAST;
        end else if (gl_q == G_LAST) begin
          state_d = S_HOLD;
          key_d   = 1'b0;
          cnt_d   = hold_last;
        end else begin
          key_d = 1'b0;
          cnt_d = BC_LAST;
          gl_d  = gl_q + G_ONE;
        end
      end
      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (BOUNCE_N == 0) begin
          press_end = 1'b1;
        end else begin
          state_d = S_R_BNC;
          key_d   = 1'b1;
          cnt_d   = BC_LAST;
          gl_d    = '0;
        end
      end
      S_R_BNC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (key_q) begin
          key_d = 1'b0;
          cnt_d = BC_LAST;
        end else if (gl_q == G_LAST) begin
          press_end = 1'b1;
        end else begin
          key_d = 1'b1;
          cnt_d = BC_LAST;
          gl_d  = gl_q + G_ONE;
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          press_d = 1'b1;
          gl_d    = '0;
          key_d   = 1'b0;
          if (BOUNCE_N == 0) begin
            state_d = S_HOLD;
            cnt_d   = hold_last;
          end else begin
            state_d = S_P_BNC;
            cnt_d   = BC_LAST;
          end
        end
      end
      S_BADCMD: begin
        state_d = S_IDLE;
        key_d   = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        key_d   = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase

    // Release finished: either pause before the second press or settle high and report.
    if (press_end) begin
      gl_d  = '0;
      key_d = 1'b1;
      if ((cmd_q == CMD_DOUBLE) && !press_q) begin
        state_d = S_GAP;
        cnt_d   = GAP_LAST;
      end else begin
        state_d = S_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  assign key_out   = key_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cmd_ready = ~busy_q;

endmodule

// File: tb/tb_key_gen.sv
// Bench for key_gen: a default-parameter instance and a bounce-free instance,
// checked cycle by cycle against a waveform model built from the press rules.
module tb_key_gen;

  localparam int BC0 = 4, BN0 = 2, SH0 = 20, LG0 = 100, GP0 = 30;
  localparam int BC1 = 3, BN1 = 0, SH1 = 5,  LG1 = 9,   GP1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1, cv0, cv1;
  logic [2:0] c0, c1;
  logic       r0, k0, b0, d0, e0;
  logic       r1, k1, b1, d1, e1;

  key_gen #(.BOUNCE_CYC(BC0), .BOUNCE_N(BN0), .SHORT_CYC(SH0), .LONG_CYC(LG0), .GAP_CYC(GP0)) u_dut0 (
    .clk(clk), .reset_n(rst0), .cmd_valid(cv0), .cmd(c0),
    .cmd_ready(r0), .key_out(k0), .busy(b0), .done(d0), .err(e0)
  );

  key_gen #(.BOUNCE_CYC(BC1), .BOUNCE_N(BN1), .SHORT_CYC(SH1), .LONG_CYC(LG1), .GAP_CYC(GP1)) u_dut1 (
    .clk(clk), .reset_n(rst1), .cmd_valid(cv1), .cmd(c1),
    .cmd_ready(r1), .key_out(k1), .busy(b1), .done(d1), .err(e1)
  );

  // Packed observation: {key_out, busy, cmd_ready, done, err}
  localparam logic [4:0] IDLE_OBS = 5'b10100;

  typedef struct {
    logic [2:0] cmd;
    int         done_cyc;
    logic       err;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [4:0] exp_q[$];
  logic [2:0] chain[$];

  function automatic logic [4:0] get_out(input int sel);
    return (sel == 0) ? {k0, b0, r0, d0, e0} : {k1, b1, r1, d1, e1};
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [2:0] c);
    if (sel == 0) begin cv0 = v; c0 = c; end
    else begin cv1 = v; c1 = c; end
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (key,busy,ready,done,err)", name, act, expv);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push_n(input int n, input logic lvl);
    for (int i = 0; i < n; i++) exp_q.push_back({lvl, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask

  // Expected per-cycle outputs for one command, cycle 1 after acceptance onward.
  task automatic model_cmd(input int sel, input logic [2:0] c);
    int bc, bn, sh, lg, gp, presses, hold;
    bc = (sel == 0) ? BC0 : BC1;
    bn = (sel == 0) ? BN0 : BN1;
    sh = (sel == 0) ? SH0 : SH1;
    lg = (sel == 0) ? LG0 : LG1;
    gp = (sel == 0) ? GP0 : GP1;
    if (c != 3'b001 && c != 3'b010 && c != 3'b100) begin
      exp_q.push_back(5'b11000);
      exp_q.push_back(5'b10111);
    end else begin
      presses = (c == 3'b010) ? 2 : 1;
      hold    = (c == 3'b100) ? lg : sh;
      for (int p = 0; p < presses; p++) begin
        for (int g = 0; g < bn; g++) begin push_n(bc, 1'b0); push_n(bc, 1'b1); end
        push_n(hold, 1'b0);
        for (int g = 0; g < bn; g++) begin push_n(bc, 1'b1); push_n(bc, 1'b0); end
        if (p == 0 && presses == 2) push_n(gp, 1'b1);
      end
      exp_q.push_back(5'b10110);
    end
  endtask

  // Issues every command in chain back to back (cmd_valid held high throughout).
  task automatic run_chain(input int sel, output int done_at, output logic err_at);
    int acc[$];
    int n;
    n = chain.size();
    exp_q.delete();
    done_at = -1;
    err_at  = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc.push_back(exp_q.size());
      model_cmd(sel, chain[i]);
    end
    @(posedge clk); #1 set_in(sel, 1'b1, chain[0]);
    @(negedge clk);
    check($sformatf("sel%0d ready at accept", sel), {4'b0, get_out(sel)[2]}, 5'b00001);
    for (int t = 1; t <= exp_q.size(); t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < n; i++)
        if (acc[i] == t - 1) begin
          if (i + 1 < n) set_in(sel, 1'b1, chain[i + 1]);
          else set_in(sel, 1'b0, 3'b000);
        end
      @(negedge clk);
      if (done_at < 0 && get_out(sel)[1]) begin
        done_at = t;
        err_at  = get_out(sel)[0];
      end
      check($sformatf("sel%0d cmd%0d t%0d", sel, chain[0], t), get_out(sel), exp_q[t - 1]);
    end
    @(negedge clk);
    check($sformatf("sel%0d idle after chain", sel), get_out(sel), IDLE_OBS);
  endtask

  vec_t       tbl[7];
  int         done_at;
  logic       err_at;
  int         seen_done;
  logic [2:0] rc;

  initial begin
    tbl[0] = '{3'b001, 53,  1'b0};
    tbl[1] = '{3'b010, 135, 1'b0};
    tbl[2] = '{3'b100, 133, 1'b0};
    tbl[3] = '{3'b011, 2,   1'b1};
    tbl[4] = '{3'b000, 2,   1'b1};
    tbl[5] = '{3'b111, 2,   1'b1};
    tbl[6] = '{3'b110, 2,   1'b1};

    rst0 = 1'b0; rst1 = 1'b0;
    set_in(0, 1'b0, 3'b000);
    set_in(1, 1'b0, 3'b000);
    repeat (3) @(negedge clk);
    check("reset state dut0", get_out(0), IDLE_OBS);
    check("reset state dut1", get_out(1), IDLE_OBS);
    rst0 = 1'b1; rst1 = 1'b1;
    @(negedge clk);
    check("post reset dut0", get_out(0), IDLE_OBS);

    // Table: completion cycle and error flag per code on the default instance.
    for (int i = 0; i < 7; i++) begin
      chain.delete();
      chain.push_back(tbl[i].cmd);
      run_chain(0, done_at, err_at);
      check_int($sformatf("done cycle cmd %b", tbl[i].cmd), done_at, tbl[i].done_cyc);
      check_int($sformatf("err flag cmd %b", tbl[i].cmd), int'(err_at), int'(tbl[i].err));
    end

    // Bounce-free instance: single click settles at 1+SHORT, then a back-to-back chain.
    chain.delete(); chain.push_back(3'b001);
    run_chain(1, done_at, err_at);
    check_int("bn0 single done cycle", done_at, 6);
    chain.delete();
    chain.push_back(3'b001); chain.push_back(3'b100); chain.push_back(3'b010);
    chain.push_back(3'b011); chain.push_back(3'b001);
    run_chain(1, done_at, err_at);
    chain.delete(); chain.push_back(3'b010); chain.push_back(3'b001);
    run_chain(0, done_at, err_at);

    // Reset pulsed during a long press: immediate abort, no done, then normal service.
    exp_q.delete();
    model_cmd(0, 3'b100);
    @(posedge clk); #1 set_in(0, 1'b1, 3'b100);
    @(posedge clk); #1 set_in(0, 1'b0, 3'b000);
    for (int t = 1; t <= 25; t++) begin
      if (t > 1) @(posedge clk);
      @(negedge clk);
      check($sformatf("abort run t%0d", t), get_out(0), exp_q[t - 1]);
    end
    #2 rst0 = 1'b0;
    #1 check("async abort", get_out(0), IDLE_OBS);
    repeat (2) @(negedge clk);
    rst0 = 1'b1;
    seen_done = 0;
    for (int t = 0; t < 150; t++) begin
      @(negedge clk);
      if (get_out(0) !== IDLE_OBS) seen_done++;
    end
    check_int("quiet after abort", seen_done, 0);
    chain.delete(); chain.push_back(3'b001);
    run_chain(0, done_at, err_at);
    check_int("accept after abort", done_at, 53);

    // Random chains on both instances.
    for (int r = 0; r < 14; r++) begin
      int sel, n, k;
      sel = int'($urandom_range(0, 1));
      n   = int'($urandom_range(1, 3));
      chain.delete();
      for (int i = 0; i < n; i++) begin
        k = int'($urandom_range(0, 9));
        if (k < 3) rc = 3'b001;
        else if (k < 6) rc = 3'b010;
        else if (k < 8) rc = 3'b100;
        else begin
          rc = 3'($urandom_range(0, 7));
          if (rc == 3'b001 || rc == 3'b010 || rc == 3'b100) rc = 3'b101;
        end
        chain.push_back(rc);
      end
      run_chain(sel, done_at, err_at);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_gen.md
KEY_GEN -- requirements
Module: key_gen

Interface
REQ-001 SHALL have parameter BOUNCE_CYC, default 4: cycles per bounce half-period (minimum 1).
REQ-002 SHALL have parameter BOUNCE_N, default 2: glitch count per edge (0 gives a clean edge).
REQ-003 SHALL have parameter SHORT_CYC, default 20: settled hold-low cycles for a click (minimum 1).
REQ-004 SHALL have parameter LONG_CYC, default 100: settled hold-low cycles for a long press (minimum 1).
REQ-005 SHALL have parameter GAP_CYC, default 30: settled high cycles between the two presses of a double click (minimum 1).
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-009 SHALL have port cmd, input, 3 bits: 3'b001 single click, 3'b010 double click, 3'b100 long press.
REQ-010 SHALL have port cmd_ready, output, 1 bit: high when idle.
REQ-011 SHALL have port key_out, output, 1 bit: emulated key line, active-low, idle high; drives a debouncer input.
REQ-012 SHALL have port busy, output, 1 bit: waveform in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port err, output, 1 bit: one-cycle pulse for an unsupported command.

Function
REQ-015 SHALL drive cmd_ready = ~busy, and SHALL accept a command in any cycle where cmd_valid and cmd_ready are both high; cmd SHALL be latched at acceptance.
REQ-016 SHALL implement the states IDLE, P_BNC, HOLD, R_BNC, GAP and BADCMD.
REQ-017 SHALL make key_out, busy, done and err registered outputs; on acceptance of a valid code, key_out SHALL go low and busy high in the next cycle.
REQ-018 SHALL, in P_BNC, drive BOUNCE_N glitches, each BOUNCE_CYC cycles low followed by BOUNCE_CYC cycles high, then enter HOLD.
REQ-019 SHALL, in HOLD, hold key_out low for SHORT_CYC cycles (single or double click) or LONG_CYC cycles (long press), then enter R_BNC.
REQ-020 SHALL, in R_BNC, drive BOUNCE_N glitches, each BOUNCE_CYC cycles high followed by BOUNCE_CYC cycles low.
REQ-021 SHALL leave R_BNC for GAP at the end of the first press of a double click, and for IDLE in all other cases.
REQ-022 SHALL, in GAP, hold key_out high for GAP_CYC cycles, then enter P_BNC for the second press.
REQ-023 SHALL, with BOUNCE_N=0, skip P_BNC and R_BNC: key_out changes level exactly once per edge.
REQ-024 SHALL, on return to IDLE, set key_out high (settled), busy low and done high for exactly one cycle.
REQ-025 SHALL treat any cmd other than the three codes as accepted: enter BADCMD for one cycle with key_out held high, and pulse done and err together in the following cycle.
REQ-026 SHALL ignore cmd_valid while busy; cmd_valid held high at the done cycle SHALL be accepted in that same cycle, giving back-to-back commands.
REQ-027 SHALL use one down-counter sized for max(BOUNCE_CYC, SHORT_CYC, LONG_CYC, GAP_CYC) cycles plus a glitch counter and a press-index bit, with no counter wrap in any state.

Reset
REQ-028 SHALL, while reset_n is low, force state IDLE, key_out=1, busy=0, cmd_ready=1, done=0, err=0, and all counters 0.
REQ-029 SHALL, on reset asserted mid-waveform, abort immediately with key_out high; no done pulse SHALL follow.
REQ-030 SHALL accept no command in the first cycle after reset release unless cmd_valid is sampled high on that edge.

Verification
REQ-031 SHALL verify single click (defaults, accept at cycle 0) -> key_out low at 1, glitches at 5-8 and 13-16 high, low 17-36, release bounce 37-52, high from 53, done=1 at 53 only, busy high cycles 1-52.
REQ-032 SHALL verify double click -> two press/release sequences separated by 30 settled-high cycles and exactly one done pulse; a debouncer plus analyser chain reports the double-click status.
REQ-033 SHALL verify long press -> settled low of 100 cycles and done at cycle 133.
REQ-034 SHALL verify cmd=3'b011 -> no key_out activity, done and err high together 2 cycles after acceptance.
REQ-035 SHALL verify reset_n pulsed low at cycle 25 of a long press -> key_out=1 and busy=0 asynchronously, no done pulse, and a new command accepted after release.
REQ-036 SHALL verify BOUNCE_N=0 with cmd_valid held high -> clean edges and back-to-back commands with no idle gap.
